// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic w_p;

  assign w_p   = a ^ b;
  assign sum   = w_p ^ cin;
  assign carry = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Adds a+b+cin LSB-first, one bit per clock; out_valid rises WIDTH edges after the accept edge.
// Result holds stable in DONE until out_ready; in_ready stays low until the result is taken.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;

  full_adder u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .cin   (r_carry),
    .sum   (w_s),
    .carry (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts the LSB lands at bit 0.
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_carry  <= w_c;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)          w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST_BIT) w_state_nxt = DONE;
      DONE:    if (out_ready)         w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  assign sum  = r_sum_sh;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks on an 8-bit adder plus a randomized handshake run on a 16-bit one.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       iv8 = 1'b0, ir8, ci8 = 1'b0, ov8, or8 = 1'b0, co8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  logic        iv16 = 1'b0, ir16, ci16 = 1'b0, ov16, or16 = 1'b0, co16;
  logic [15:0] a16 = '0, b16 = '0, s16;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .cin       (ci8),
    .out_valid (ov8),
    .out_ready (or8),
    .sum       (s8),
    .cout      (co8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .cin       (ci16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (s16),
    .cout      (co16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge with the 8-bit DUT idle; returns on the negedge after the accept edge.
  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int t;
    t = 0;
    while (!ir8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("start_rdy", ir8, 1);
    a8  = av;
    b8  = bv;
    ci8 = cv;
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic finish8(input string tag, input logic [7:0] es, input logic ec, input int hold);
    int lat;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, s8, es);
    chk({tag, "_cout"}, co8, ec);
    chk({tag, "_busy"}, ir8, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_sum"}, s8, es);
      chk({tag, "_hold_cout"}, co8, ec);
      chk({tag, "_hold_vld"}, ov8, 1);
      chk({tag, "_hold_rdy"}, ir8, 0);
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk({tag, "_idle_rdy"}, ir8, 1);
    chk({tag, "_idle_vld"}, ov8, 0);
  endtask

  task automatic rand16(input int n_ops);
    logic [16:0] exp_q[$];
    logic [16:0] e;
    logic        pend;
    int          ops;
    int          cyc;
    pend = 1'b0;
    ops  = 0;
    cyc  = 0;
    while (ops < n_ops && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        iv16 = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          a16  = 16'($urandom);
          b16  = 16'($urandom);
          ci16 = 1'($urandom);
          iv16 = 1'b1;
          pend = 1'b1;
        end
      end
      or16 = ($urandom_range(0, 2) != 0);
      if (iv16 && ir16) begin
        exp_q.push_back({1'b0, a16} + {1'b0, b16} + 17'(ci16));
        pend = 1'b0;
      end
      if (ov16 && or16) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_sum", s16, e[15:0]);
          chk("rnd_cout", co16, e[16]);
        end
        ops++;
      end
    end
    iv16 = 1'b0;
    or16 = 1'b0;
    chk("rnd_ops_done", ops, n_ops);
  endtask

  initial begin
    int lat;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_cout", co8, 0);
    chk("rst16_in_ready", ir16, 1);
    chk("rst16_sum", s16, 0);
    rst_n = 1'b1;
    @(negedge clk);

    start8(8'h5A, 8'h3C, 1'b0);
    finish8("basic", 8'h96, 1'b0, 0);

    start8(8'hFF, 8'h01, 1'b0);
    finish8("wrap", 8'h00, 1'b1, 0);
    start8(8'hFF, 8'h00, 1'b1);
    finish8("cin_wrap", 8'h00, 1'b1, 0);

    start8(8'hC3, 8'h55, 1'b0);
    finish8("bp", 8'h18, 1'b1, 5);

    // Reset in the middle of RUN.
    start8(8'hAA, 8'h55, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", ir8, 1);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_sum", s8, 0);
    chk("midrst_cout", co8, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    chk("midrst_no_result", ov8, 0);
    start8(8'h12, 8'h34, 1'b0);
    finish8("post_rst", 8'h46, 1'b0, 0);

    // in_valid stays high while operands churn during RUN.
    a8  = 8'h0F;
    b8  = 8'h01;
    ci8 = 1'b0;
    iv8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!ov8 && lat < 20) begin
      chk("held_busy", ir8, 0);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("held_lat", lat, 8);
    chk("held_sum", s8, 8'h10);
    chk("held_cout", co8, 0);
    @(negedge clk);
    chk("held_done_rdy", ir8, 0);
    chk("held_done_vld", ov8, 1);
    a8  = 8'h20;
    b8  = 8'h03;
    ci8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("held_back_idle", ir8, 1);
    chk("held_back_vld", ov8, 0);
    @(negedge clk);
    iv8 = 1'b0;
    chk("held_reaccept", ir8, 0);
    finish8("held2", 8'h23, 1'b0, 0);

    rand16(250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
